// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, parity sense, line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Takes three mid-bit samples of the synchronised line and registers their majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int EW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_s,
    input  logic [EW-1:0] edge_cnt,
    output logic          sampled_bit,
    output logic          sample_valid
);
    localparam logic [EW-1:0] S0 = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] S1 = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] S2 = EW'(PRESCALE / 2 + 1);

    logic s0, s1;

    // The third sample is taken straight from the line so the vote lands at the end of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0           <= LINE_IDLE;
            s1           <= LINE_IDLE;
            sampled_bit  <= LINE_IDLE;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (edge_cnt == S0) s0 <= rx_s;
            if (edge_cnt == S1) s1 <= rx_s;
            if (edge_cnt == S2) begin
                sampled_bit  <= maj3(s0, s1, rx_s);
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start/data/parity/stop FSM and registered result pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int in_width    = 8,
    parameter int PRESCALE    = 8,
    parameter int count_width = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RX_IN,
    input  logic                parity_EN,
    input  logic                parity_type,
    output logic [in_width-1:0] P_DATA,
    output logic                data_valid,
    output logic                parity_error,
    output logic                stop_error,
    output logic                rx_busy
);
    localparam int EW = $clog2(PRESCALE);
    localparam logic [EW-1:0]          LAST_EDGE = EW'(PRESCALE - 1);
    localparam logic [count_width-1:0] LAST_BIT  = count_width'(in_width - 1);

    logic                   rx_meta, rx_s;
    rx_state_t              state, state_nxt;
    logic [EW-1:0]          edge_cnt;
    logic [count_width-1:0] bit_cnt;
    logic [in_width-1:0]    shift_reg;
    logic                   par_en_l, par_type_l, par_bad;
    logic                   vote, vote_vld;
    logic                   last_edge, last_bit, start_det;

    assign last_edge = (edge_cnt == LAST_EDGE);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign start_det = (state == IDLE) && (rx_s != LINE_IDLE);
    assign rx_busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= LINE_IDLE;
            rx_s    <= LINE_IDLE;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    uart_rx_sampler #(
        .PRESCALE (PRESCALE),
        .EW       (EW)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_s         (rx_s),
        .edge_cnt     (edge_cnt),
        .sampled_bit  (vote),
        .sample_valid (vote_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (rx_s != LINE_IDLE) state_nxt = START;
            START: begin
                if (vote_vld && vote == LINE_IDLE) state_nxt = IDLE;
                else if (last_edge)                state_nxt = DATA;
            end
            DATA:   if (last_edge && last_bit) state_nxt = par_en_l ? PARITY : STOP;
            PARITY: if (last_edge) state_nxt = STOP;
            // Leave half a bit early so a following start edge is caught on time.
            STOP:   if (vote_vld) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_en_l     <= 1'b0;
            par_type_l   <= PARITY_EVEN;
            par_bad      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            if (state == IDLE || state_nxt == IDLE || last_edge) edge_cnt <= '0;
            else                                                 edge_cnt <= edge_cnt + 1'b1;

            if (state == START)                            bit_cnt <= '0;
            else if (state == DATA && last_edge && !last_bit) bit_cnt <= bit_cnt + 1'b1;

            if (start_det) begin
                par_en_l   <= parity_EN;
                par_type_l <= parity_type;
                par_bad    <= 1'b0;
            end

            if (state == DATA && vote_vld) begin
                for (int i = 0; i < in_width; i++)
                    if (bit_cnt == count_width'(i)) shift_reg[i] <= vote;
            end

            if (state == PARITY && vote_vld)
                par_bad <= vote != (^shift_reg ^ (par_type_l == PARITY_ODD));

            if (state == STOP && vote_vld) begin
                stop_error   <= (vote != LINE_IDLE);
                parity_error <= par_en_l & par_bad;
                if (vote == LINE_IDLE && !(par_en_l && par_bad)) begin
                    data_valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue checked every cycle, plus literal checks.
module tb_uart_rx;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst, RX_IN, parity_EN, parity_type;
    logic [7:0] P_DATA;
    logic       data_valid, parity_error, stop_error, rx_busy;

    uart_rx #(.in_width(8), .PRESCALE(P), .count_width(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .parity_EN    (parity_EN),
        .parity_type  (parity_type),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One entry per frame that must produce a result pulse, with an arrival window in cycles.
    typedef struct {
        logic       pe;
        logic       se;
        logic [7:0] d;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       expq[$];
    exp_t       ce;
    logic [7:0] obs[$];
    logic [7:0] m_pdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_pdata = 8'h00;
        end else begin
            if (data_valid | parity_error | stop_error) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", {data_valid, parity_error, stop_error}, 3'b000);
                end else begin
                    ce = expq.pop_front();
                    chk("pulse_flags", {data_valid, parity_error, stop_error},
                        {~(ce.pe | ce.se), ce.pe, ce.se});
                    chk("pulse_window", (cyc >= ce.lo && cyc <= ce.hi), 1);
                    if (!(ce.pe | ce.se)) m_pdata = ce.d;
                end
                if (data_valid) obs.push_back(P_DATA);
            end else if (expq.size() != 0 && cyc > expq[0].hi) begin
                chk("pulse_timeout", 0, 1);
                void'(expq.pop_front());
            end
            chk("P_DATA_model", P_DATA, m_pdata);
        end
    end

    task automatic line_bit(input logic b, input int glitch_at);
        for (int i = 0; i < P; i++) begin
            RX_IN = (i == glitch_at) ? ~b : b;
            @(posedge clk);
        end
    endtask

    // Result due about (8+1)*8 + 8/2 + 3 = 79 clks after the line fall, plus one bit with parity.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                              input logic pflip, input logic stopb, input int g0);
        exp_t e;
        logic pb;
        int   t0;
        parity_EN   = pen;
        parity_type = ptype;
        pb   = ^d ^ ptype ^ pflip;
        t0   = cyc;
        e.pe = pen & pflip;
        e.se = ~stopb;
        e.d  = d;
        e.lo = t0 + 74 + (pen ? P : 0);
        e.hi = t0 + 87 + (pen ? P : 0);
        expq.push_back(e);
        line_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) line_bit(d[i], (i == 0) ? g0 : -1);
        if (pen) line_bit(pb, -1);
        line_bit(stopb, -1);
    endtask

    task automatic drain(input string nm, input logic [7:0] want);
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_drain"}, (n < 300), 1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk({nm, "_P_DATA"}, P_DATA, want);
        chk({nm, "_busy"}, rx_busy, 0);
        @(posedge clk);
    endtask

    initial begin
        int seen;
        int base;
        rst         = 1'b1;
        RX_IN       = 1'b1;
        parity_EN   = 1'b0;
        parity_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_P_DATA", P_DATA, 8'h00);
        chk("reset_valid", data_valid, 0);
        chk("reset_perr", parity_error, 0);
        chk("reset_serr", stop_error, 0);
        chk("reset_busy", rx_busy, 0);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        drain("a5", 8'hA5);

        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        drain("3c_par_ok", 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        RX_IN = 1'b1;
        drain("3c_par_bad", 8'h3C);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        RX_IN = 1'b1;
        drain("55_stop_bad", 8'h3C);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        drain("81", 8'h81);

        // Short idle glitch: busy must rise, then fall without any report.
        RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        RX_IN = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rx_busy) seen = 1;
        end
        chk("glitch_busy_seen", seen, 1);
        @(posedge clk);
        drain("idle_glitch", 8'h81);

        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        RX_IN = 1'b1;
        drain("ff_glitch", 8'hFF);

        base = obs.size();
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        drain("b2b", 8'h34);
        chk("b2b_count", obs.size() - base, 2);
        chk("b2b_first", obs[base], 8'h12);
        chk("b2b_second", obs[base+1], 8'h34);

        // Reset in the middle of data bit 3 abandons the frame.
        RX_IN = 1'b0;
        repeat (P) @(posedge clk);
        line_bit(1'b1, -1);
        line_bit(1'b0, -1);
        line_bit(1'b1, -1);
        RX_IN = 1'b1;
        repeat (4) @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_P_DATA", P_DATA, 8'h00);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_pulses", {data_valid, parity_error, stop_error}, 3'b000);
        repeat (20) @(posedge clk);
        send_frame(8'h9C, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        RX_IN = 1'b1;
        drain("9c_after_rst", 8'h9C);

        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
